fp32_recip_mul_pipe: RTL and testbench

//   Pipelined FP32 multiplier that follows the reciprocal unit. It forms
//   a/b = num * (1/b): it takes a numerator and the reciprocal produced

---
 rtl/fp32_recip_mul_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_fp32_recip_mul_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_recip_mul_pipe.sv
// fp32_recip_mul_pipe: three-stage FP32 multiplier forming num * (1/b).
// S1 unpacks and classifies operands, S2 forms the 48-bit mantissa product,
// S3 normalises, rounds and registers the result and flags.
// Each stage advances when it is empty or its successor advances, so bubbles
// collapse and a stalled consumer back-pressures all the way to in_ready.
module fp32_recip_mul_pipe #(
  parameter bit          ROUND_EN = 1'b1,
  parameter logic [31:0] NAN_OUT  = 32'h7FC00001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num,
  input  logic [31:0] recip,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  // Flow control
  logic w_adv1, w_adv2, w_adv3;

  // Stage 1 registers
  logic               r_v1;
  logic               r_s1_sign;
  logic signed [9:0]  r_s1_exp;
  logic [23:0]        r_s1_ma, r_s1_mb;
  logic               r_s1_spec;
  logic [31:0]        r_s1_spec_res;
  logic [3:0]         r_s1_spec_flags;

  // Stage 2 registers
  logic               r_v2;
  logic               r_s2_sign;
  logic signed [9:0]  r_s2_exp;
  logic [47:0]        r_s2_prod;
  logic               r_s2_spec;
  logic [31:0]        r_s2_spec_res;
  logic [3:0]         r_s2_spec_flags;

  // Stage 3 (output) registers
  logic               r_v3;
  logic [31:0]        r_out_result;
  logic [3:0]         r_out_flags;

  // Stage 1 combinational unpack
  logic               w_s1_sign;
  logic signed [9:0]  w_s1_exp;
  logic               w_a_zero, w_a_inf, w_a_nan;
  logic               w_b_zero, w_b_inf, w_b_nan;
  logic               w_s1_spec;
  logic [31:0]        w_s1_spec_res;
  logic [3:0]         w_s1_spec_flags;

  // Stage 3 combinational normalise/round
  logic [22:0]        w_mant;
  logic               w_guard, w_sticky, w_inc, w_carry;
  logic [22:0]        w_mant_r;
  logic signed [9:0]  w_e_n, w_e_r;
  logic [31:0]        w_res;
  logic [3:0]         w_flags;

  assign w_adv3   = !r_v3 | out_ready;
  assign w_adv2   = !r_v2 | w_adv3;
  assign w_adv1   = !r_v1 | w_adv2;
  assign in_ready = w_adv1;

  assign out_valid  = r_v3;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

  assign w_s1_sign = num[31] ^ recip[31];
  assign w_s1_exp  = $signed({2'b00, num[30:23]}) + $signed({2'b00, recip[30:23]}) - 10'sd127;

  // Exponent zero is flushed to zero, so subnormal inputs behave as zero
  assign w_a_zero = (num[30:23] == 8'h00);
  assign w_a_inf  = (num[30:23] == 8'hFF) && (num[22:0] == 23'd0);
  assign w_a_nan  = (num[30:23] == 8'hFF) && (num[22:0] != 23'd0);
  assign w_b_zero = (recip[30:23] == 8'h00);
  assign w_b_inf  = (recip[30:23] == 8'hFF) && (recip[22:0] == 23'd0);
  assign w_b_nan  = (recip[30:23] == 8'hFF) && (recip[22:0] != 23'd0);

  // Special-operand classification; NaN takes priority over Inf*zero
  always_comb begin
    w_s1_spec       = 1'b0;
    w_s1_spec_res   = '0;
    w_s1_spec_flags = '0;
    if (w_a_nan || w_b_nan) begin
      w_s1_spec     = 1'b1;
      w_s1_spec_res = NAN_OUT;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_s1_spec       = 1'b1;
      w_s1_spec_res   = NAN_OUT;
      w_s1_spec_flags = 4'b1000;
    end else if (w_a_inf || w_b_inf) begin
      w_s1_spec     = 1'b1;
      w_s1_spec_res = {w_s1_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_s1_spec     = 1'b1;
      w_s1_spec_res = {w_s1_sign, 31'd0};
    end
  end

  // Stage 1: capture unpacked operands with hidden bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1            <= 1'b0;
      r_s1_sign       <= 1'b0;
      r_s1_exp        <= '0;
      r_s1_ma         <= '0;
      r_s1_mb         <= '0;
      r_s1_spec       <= 1'b0;
      r_s1_spec_res   <= '0;
      r_s1_spec_flags <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_sign       <= w_s1_sign;
        r_s1_exp        <= w_s1_exp;
        r_s1_ma         <= {1'b1, num[22:0]};
        r_s1_mb         <= {1'b1, recip[22:0]};
        r_s1_spec       <= w_s1_spec;
        r_s1_spec_res   <= w_s1_spec_res;
        r_s1_spec_flags <= w_s1_spec_flags;
      end
    end
  end

  // Stage 2: 24x24 mantissa product, specials carried alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2            <= 1'b0;
      r_s2_sign       <= 1'b0;
      r_s2_exp        <= '0;
      r_s2_prod       <= '0;
      r_s2_spec       <= 1'b0;
      r_s2_spec_res   <= '0;
      r_s2_spec_flags <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_sign       <= r_s1_sign;
        r_s2_exp        <= r_s1_exp;
        r_s2_prod       <= r_s1_ma * r_s1_mb;
        r_s2_spec       <= r_s1_spec;
        r_s2_spec_res   <= r_s1_spec_res;
        r_s2_spec_flags <= r_s1_spec_flags;
      end
    end
  end

  // Normalise, round-to-nearest-even, and range-check the exponent
  always_comb begin
    if (r_s2_prod[47]) begin
      w_mant   = r_s2_prod[46:24];
      w_guard  = r_s2_prod[23];
      w_sticky = |r_s2_prod[22:0];
      w_e_n    = r_s2_exp + 10'sd1;
    end else begin
      w_mant   = r_s2_prod[45:23];
      w_guard  = r_s2_prod[22];
      w_sticky = |r_s2_prod[21:0];
      w_e_n    = r_s2_exp;
    end
    w_inc = ROUND_EN && w_guard && (w_sticky || w_mant[0]);
    {w_carry, w_mant_r} = {1'b0, w_mant} + {23'd0, w_inc};
    // A rounding carry leaves the mantissa at zero and bumps the exponent
    w_e_r = w_carry ? (w_e_n + 10'sd1) : w_e_n;

    w_res   = '0;
    w_flags = '0;
    if (r_s2_spec) begin
      w_res   = r_s2_spec_res;
      w_flags = r_s2_spec_flags;
    end else if (w_e_r >= 10'sd255) begin
      w_res   = {r_s2_sign, 8'hFF, 23'd0};
      w_flags = 4'b0101;
    end else if (w_e_r <= 10'sd0) begin
      // Arithmetic path operands are nonzero, so the flushed result is inexact
      w_res   = {r_s2_sign, 31'd0};
      w_flags = 4'b0011;
    end else begin
      w_res   = {r_s2_sign, w_e_r[7:0], w_mant_r};
      w_flags = {3'b000, w_guard | w_sticky};
    end
  end

  // Stage 3: registered result, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3         <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out_result <= w_res;
        r_out_flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32_recip_mul_pipe.sv
// Directed bench for fp32_recip_mul_pipe: arithmetic vectors with hand-computed
// results, a truncating instance fed in parallel, back-pressure and reset.
module tb_fp32_recip_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] num, recip;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        t_in_ready, t_out_valid;
  logic [31:0] t_out_result;
  logic [3:0]  t_out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp32_recip_mul_pipe #(.ROUND_EN(1'b1), .NAN_OUT(32'h7FC00001)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .recip(recip), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  fp32_recip_mul_pipe #(.ROUND_EN(1'b0)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
    .num(num), .recip(recip), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_result(t_out_result), .out_flags(t_out_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    logic [31:0] t;
  } vec_t;

  vec_t vecs [19];

  // Single operation with out_ready=1: checks latency, result, flags, truncated result
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f, input logic [31:0] t);
    int cyc;
    num       = a;
    recip     = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd3);
    check({tag, "_result"}, out_result, r);
    check({tag, "_flags"}, {28'd0, out_flags}, {28'd0, f});
    check({tag, "_trunc"}, t_out_result, t);
    @(posedge clk); #1;
  endtask

  logic [31:0] sa [4];
  logic [31:0] se [4];

  initial begin
    int idx;
    int got;
    int budget;
    logic hs;

    vecs[0]  = '{32'h40000000, 32'h3F000000, 32'h3F800000, 4'b0000, 32'h3F800000};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 32'h3F800002};
    vecs[2]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 32'h7F800000};
    vecs[3]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 32'h00000000};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00001, 4'b1000, 32'h7FC00001};
    vecs[5]  = '{32'h7FC12345, 32'h3F800000, 32'h7FC00001, 4'b0000, 32'h7FC00001};
    vecs[6]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 32'h3FC00001};
    vecs[7]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 32'h3FC00004};
    vecs[8]  = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001, 32'h3FFFFFFF};
    vecs[9]  = '{32'hC0000000, 32'h3F000000, 32'hBF800000, 4'b0000, 32'hBF800000};
    vecs[10] = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0000, 32'hFF800000};
    vecs[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 32'h80000000};
    vecs[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[13] = '{32'h3F800000, 32'hFFC00000, 32'h7FC00001, 4'b0000, 32'h7FC00001};
    vecs[14] = '{32'h7FC00000, 32'h00000000, 32'h7FC00001, 4'b0000, 32'h7FC00001};
    vecs[15] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 32'h7F7FFFFF};
    vecs[16] = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 32'h40000000};
    vecs[17] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000, 32'h7F800000};
    vecs[18] = '{32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 32'h80000000};

    sa[0] = 32'h3F800000; se[0] = 32'h40000000;
    sa[1] = 32'h40000000; se[1] = 32'h40800000;
    sa[2] = 32'h40400000; se[2] = 32'h40C00000;
    sa[3] = 32'h40800000; se[3] = 32'h41000000;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; num = '0; recip = '0;
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_flags", {28'd0, out_flags}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++)
      run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f, vecs[i].t);

    // Back-pressure: four ops offered back to back while the consumer stalls
    recip     = 32'h40000000;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx       = 0;
    num       = sa[0];
    for (int c = 0; c < 5; c++) begin
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < 4) num = sa[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) check($sformatf("stall_hold_c%0d", c), out_result, se[0]);
    end
    check("stall_accepts", idx, 32'd3);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);

    out_ready = 1'b1;
    got    = 0;
    budget = 0;
    while (got < 4 && budget < 20) begin
      hs = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("drain_%0d", got), out_result, se[got]);
        got++;
      end
      @(posedge clk); #1;
      budget++;
      if (hs) begin
        idx++;
        if (idx < 4) num = sa[idx];
        else in_valid = 1'b0;
      end
    end
    check("drain_count", got, 32'd4);
    @(posedge clk); #1;
    check("drain_no_extra", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    num       = sa[1];
    @(posedge clk); #1;
    num = sa[2];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_out_result", out_result, 32'd0);
    check("rst_async_out_flags", {28'd0, out_flags}, 32'd0);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle_%0d", c), {31'd0, out_valid}, 32'd0);
    end
    run_op("post_rst", 32'h40000000, 32'h3F000000, 32'h3F800000, 4'b0000, 32'h3F800000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
